// File: rtl/operand_fetch_stage_if.sv
// Decode-side and execute-side handshake bundle for the operand fetch stage.
// The stage itself connects through slave; the surrounding pipeline uses master.
interface operand_fetch_stage_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5,
   parameter int CTRL_WIDTH    = 16
);
   logic                     in_valid;
   logic                     in_ready;
   logic [ADDRESS_WIDTH-1:0] in_rs1;
   logic [ADDRESS_WIDTH-1:0] in_rs2;
   logic [ADDRESS_WIDTH-1:0] in_rd;
   logic [DATA_WIDTH-1:0]    in_imm;
   logic [DATA_WIDTH-1:0]    in_pc;
   logic [CTRL_WIDTH-1:0]    in_ctrl;

   logic                     out_valid;
   logic                     out_ready;
   logic [DATA_WIDTH-1:0]    out_op1;
   logic [DATA_WIDTH-1:0]    out_op2;
   logic [ADDRESS_WIDTH-1:0] out_rs1;
   logic [ADDRESS_WIDTH-1:0] out_rs2;
   logic [ADDRESS_WIDTH-1:0] out_rd;
   logic [DATA_WIDTH-1:0]    out_imm;
   logic [DATA_WIDTH-1:0]    out_pc;
   logic [CTRL_WIDTH-1:0]    out_ctrl;

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_imm, in_pc, in_ctrl, out_ready,
      output in_ready, out_valid, out_op1, out_op2, out_rs1, out_rs2, out_rd,
             out_imm, out_pc, out_ctrl
   );

   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_imm, in_pc, in_ctrl, out_ready,
      input  in_ready, out_valid, out_op1, out_op2, out_rs1, out_rs2, out_rd,
             out_imm, out_pc, out_ctrl
   );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch pipeline register: reads the register file, bypasses same-cycle
// writebacks, and keeps held operands current while execute is stalled.
module operand_fetch_stage #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5,
   parameter int CTRL_WIDTH    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   operand_fetch_stage_if.slave     bus,
   output logic [ADDRESS_WIDTH-1:0] rf_ad1,
   output logic [ADDRESS_WIDTH-1:0] rf_ad2,
   input  logic [DATA_WIDTH-1:0]    rf_rd1,
   input  logic [DATA_WIDTH-1:0]    rf_rd2,
   input  logic                     wb_we,
   input  logic [ADDRESS_WIDTH-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0]    wb_data,
   input  logic                     flush
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t                   state_reg, state_next;
   logic [DATA_WIDTH-1:0]    op_reg [2];
   logic [DATA_WIDTH-1:0]    op_next [2];
   logic [ADDRESS_WIDTH-1:0] rs1_reg, rs1_next, rs2_reg, rs2_next, rd_reg, rd_next;
   logic [DATA_WIDTH-1:0]    imm_reg, imm_next, pc_reg, pc_next;
   logic [CTRL_WIDTH-1:0]    ctrl_reg, ctrl_next;

   logic [ADDRESS_WIDTH-1:0] src_addr [2];
   logic [ADDRESS_WIDTH-1:0] held_src [2];
   logic [DATA_WIDTH-1:0]    rf_data [2];
   logic [DATA_WIDTH-1:0]    resolved [2];
   logic                     held_hit [2];
   logic                     in_ready_int;
   logic                     load;

   assign src_addr[0] = bus.in_rs1;
   assign src_addr[1] = bus.in_rs2;
   assign held_src[0] = rs1_reg;
   assign held_src[1] = rs2_reg;
   assign rf_data[0]  = rf_rd1;
   assign rf_data[1]  = rf_rd2;
   assign rf_ad1      = bus.in_rs1;
   assign rf_ad2      = bus.in_rs2;

   // x0 is forced to zero; otherwise a same-cycle writeback overrides the array read.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         assign resolved[gi] = (src_addr[gi] == '0) ? '0 :
                               (wb_we && wb_addr == src_addr[gi]) ? wb_data : rf_data[gi];
         assign held_hit[gi] = wb_we && (wb_addr != '0) && (wb_addr == held_src[gi]);
      end
   endgenerate

   assign in_ready_int = (state_reg == EMPTY) || bus.out_ready;
   assign load         = bus.in_valid && in_ready_int;

   always_comb begin
      state_next = state_reg;
      for (int i = 0; i < 2; i++) op_next[i] = op_reg[i];
      rs1_next  = rs1_reg;
      rs2_next  = rs2_reg;
      rd_next   = rd_reg;
      imm_next  = imm_reg;
      pc_next   = pc_reg;
      ctrl_next = ctrl_reg;
      if (flush) begin
         state_next = EMPTY;
      end else if (load) begin
         state_next = FULL;
         for (int i = 0; i < 2; i++) op_next[i] = resolved[i];
         rs1_next  = bus.in_rs1;
         rs2_next  = bus.in_rs2;
         rd_next   = bus.in_rd;
         imm_next  = bus.in_imm;
         pc_next   = bus.in_pc;
         ctrl_next = bus.in_ctrl;
      end else if (state_reg == FULL && bus.out_ready) begin
         state_next = EMPTY;
      end else if (state_reg == FULL) begin
         // Stalled: a writeback to a held source would otherwise be missed for good.
         for (int i = 0; i < 2; i++) if (held_hit[i]) op_next[i] = wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= EMPTY;
         for (int i = 0; i < 2; i++) op_reg[i] <= '0;
         rs1_reg  <= '0;
         rs2_reg  <= '0;
         rd_reg   <= '0;
         imm_reg  <= '0;
         pc_reg   <= '0;
         ctrl_reg <= '0;
      end else begin
         state_reg <= state_next;
         for (int i = 0; i < 2; i++) op_reg[i] <= op_next[i];
         rs1_reg  <= rs1_next;
         rs2_reg  <= rs2_next;
         rd_reg   <= rd_next;
         imm_reg  <= imm_next;
         pc_reg   <= pc_next;
         ctrl_reg <= ctrl_next;
      end
   end

   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = (state_reg == FULL);
   assign bus.out_op1   = op_reg[0];
   assign bus.out_op2   = op_reg[1];
   assign bus.out_rs1   = rs1_reg;
   assign bus.out_rs2   = rs2_reg;
   assign bus.out_rd    = rd_reg;
   assign bus.out_imm   = imm_reg;
   assign bus.out_pc    = pc_reg;
   assign bus.out_ctrl  = ctrl_reg;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: reset, pass-through, bypass, stall
// update, streaming order under back-pressure, and flush.
module tb_operand_fetch_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rf_ad1, rf_ad2;
   logic [31:0] rf_rd1, rf_rd2;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;
   int          vectors = 0;
   int          miscompares = 0;

   operand_fetch_stage_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .CTRL_WIDTH(16)) bus ();

   operand_fetch_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .CTRL_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .rf_ad1(rf_ad1), .rf_ad2(rf_ad2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [15:0] ctrl);
      bus.in_valid = 1'b1;
      bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd;
      bus.in_imm = imm; bus.in_pc = pc; bus.in_ctrl = ctrl;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
      rf_rd1 = 32'h99; rf_rd2 = 32'h98; bus.out_ready = 1'b0;
      offer(5'd1, 5'd2, 5'd3, 32'h44, 32'h80, 16'hFFFF);
      step(); step();
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid);
      end
      vectors++;
      if ({bus.out_op1, bus.out_op2, bus.out_imm, bus.out_pc} !== 128'h0) begin
         miscompares++;
         $display("FAIL reset_data: got %h %h %h %h expected all 0",
                  bus.out_op1, bus.out_op2, bus.out_imm, bus.out_pc);
      end
      vectors++;
      if ({bus.out_ctrl, bus.out_rs1, bus.out_rs2, bus.out_rd} !== 31'h0) begin
         miscompares++;
         $display("FAIL reset_fields: got %h %h %h %h expected all 0",
                  bus.out_ctrl, bus.out_rs1, bus.out_rs2, bus.out_rd);
      end
      rst = 1'b0; bus.in_valid = 1'b0;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      end
      $display("reset: out_valid=%b in_ready=%b", bus.out_valid, bus.in_ready);
   endtask

   task automatic test_pass_through();
      rf_rd1 = 32'h11; rf_rd2 = 32'h22; bus.out_ready = 1'b1;
      offer(5'd3, 5'd4, 5'd9, 32'h5, 32'h100, 16'hA5A5);
      #1;
      vectors++;
      if (rf_ad1 !== 5'd3 || rf_ad2 !== 5'd4) begin
         miscompares++; $display("FAIL rf_addr: got %0d %0d expected 3 4", rf_ad1, rf_ad2);
      end
      step();
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_op1 !== 32'h11 || bus.out_op2 !== 32'h22) begin
         miscompares++;
         $display("FAIL pass_ops: got v=%b %h %h expected v=1 00000011 00000022",
                  bus.out_valid, bus.out_op1, bus.out_op2);
      end
      vectors++;
      if (bus.out_pc !== 32'h100 || bus.out_imm !== 32'h5 || bus.out_ctrl !== 16'hA5A5 ||
          bus.out_rd !== 5'd9 || bus.out_rs1 !== 5'd3 || bus.out_rs2 !== 5'd4) begin
         miscompares++;
         $display("FAIL pass_fields: got pc=%h imm=%h ctrl=%h rd=%0d rs=%0d,%0d expected 100 5 a5a5 9 3,4",
                  bus.out_pc, bus.out_imm, bus.out_ctrl, bus.out_rd, bus.out_rs1, bus.out_rs2);
      end
      $display("pass_through: op1=%h op2=%h pc=%h", bus.out_op1, bus.out_op2, bus.out_pc);
      step();
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++; $display("FAIL drain: got out_valid=%b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_bypass();
      rf_rd1 = 32'h1; rf_rd2 = 32'h55; bus.out_ready = 1'b1;
      wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
      offer(5'd7, 5'd0, 5'd1, 32'h0, 32'h104, 16'h1);
      step();
      vectors++;
      if (bus.out_op1 !== 32'hDEADBEEF || bus.out_op2 !== 32'h0) begin
         miscompares++;
         $display("FAIL bypass_hit: got %h %h expected deadbeef 00000000", bus.out_op1, bus.out_op2);
      end
      $display("bypass: op1=%h op2=%h", bus.out_op1, bus.out_op2);
      wb_addr = 5'd0;
      offer(5'd7, 5'd0, 5'd1, 32'h0, 32'h108, 16'h2);
      step();
      vectors++;
      if (bus.out_op1 !== 32'h1 || bus.out_op2 !== 32'h0 || bus.out_pc !== 32'h108) begin
         miscompares++;
         $display("FAIL bypass_x0_wb: got %h %h pc=%h expected 00000001 00000000 108",
                  bus.out_op1, bus.out_op2, bus.out_pc);
      end
      $display("bypass_wb_x0: op1=%h op2=%h", bus.out_op1, bus.out_op2);
      wb_we = 1'b0; bus.in_valid = 1'b0;
      step();
   endtask

   task automatic test_stall_update();
      rf_rd1 = 32'h10; rf_rd2 = 32'h20; bus.out_ready = 1'b0;
      offer(5'd5, 5'd5, 5'd2, 32'h0, 32'h200, 16'h3);
      step();
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_op1 !== 32'h10 || bus.out_op2 !== 32'h20) begin
         miscompares++;
         $display("FAIL stall_load: got v=%b %h %h expected v=1 00000010 00000020",
                  bus.out_valid, bus.out_op1, bus.out_op2);
      end
      wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h1234;
      step();
      vectors++;
      if (bus.out_op1 !== 32'h10 || bus.out_op2 !== 32'h20) begin
         miscompares++;
         $display("FAIL stall_miss: got %h %h expected 00000010 00000020", bus.out_op1, bus.out_op2);
      end
      wb_addr = 5'd5; wb_data = 32'hCAFE;
      step();
      wb_we = 1'b0;
      vectors++;
      if (bus.out_op1 !== 32'hCAFE || bus.out_op2 !== 32'hCAFE || bus.out_valid !== 1'b1 ||
          bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_update: got %h %h v=%b rdy=%b expected 0000cafe 0000cafe v=1 rdy=0",
                  bus.out_op1, bus.out_op2, bus.out_valid, bus.in_ready);
      end
      $display("stall_update: op1=%h op2=%h", bus.out_op1, bus.out_op2);
      bus.out_ready = 1'b1;
      step();
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++; $display("FAIL stall_drain: got out_valid=%b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] ready_pat;
      int sent = 0;
      int got = 0;
      int cycles = 0;
      ready_pat = 5'b01101;
      while (got < 8 && cycles < 100) begin
         bus.out_ready = ready_pat[cycles % 5];
         if (sent < 8) begin
            offer(5'(sent + 1), 5'(sent + 9), 5'(sent + 17), 32'(sent), 32'h400 + 32'(4 * sent), 16'(sent));
            rf_rd1 = 32'h1000 + 32'(sent); rf_rd2 = 32'h2000 + 32'(sent);
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (bus.out_valid && bus.out_ready) begin
            vectors++;
            if (bus.out_pc !== 32'h400 + 32'(4 * got) || bus.out_op1 !== 32'h1000 + 32'(got) ||
                bus.out_op2 !== 32'h2000 + 32'(got)) begin
               miscompares++;
               $display("FAIL stream_order: got pc=%h op1=%h op2=%h expected pc=%h op1=%h op2=%h",
                        bus.out_pc, bus.out_op1, bus.out_op2, 32'h400 + 32'(4 * got),
                        32'h1000 + 32'(got), 32'h2000 + 32'(got));
            end
            $display("stream: beat %0d pc=%h op1=%h", got, bus.out_pc, bus.out_op1);
            got++;
         end
         if (bus.in_valid && bus.in_ready) sent++;
         step();
         cycles++;
      end
      bus.in_valid = 1'b0;
      vectors++;
      if (got !== 8 || sent !== 8) begin
         miscompares++; $display("FAIL stream_count: got %0d out %0d in, expected 8 8", got, sent);
      end
      bus.out_ready = 1'b1;
      step();
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++; $display("FAIL stream_dup: got out_valid=%b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_flush();
      rf_rd1 = 32'hA; rf_rd2 = 32'hB; bus.out_ready = 1'b0;
      offer(5'd1, 5'd2, 5'd3, 32'h0, 32'h300, 16'h0);
      step();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h300) begin
         miscompares++; $display("FAIL flush_setup: got v=%b pc=%h expected v=1 300", bus.out_valid, bus.out_pc);
      end
      offer(5'd1, 5'd2, 5'd3, 32'h0, 32'h304, 16'h0);
      flush = 1'b1;
      step();
      flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++; $display("FAIL flush_full: got out_valid=%b expected 0", bus.out_valid);
      end
      step();
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++; $display("FAIL flush_ghost: got out_valid=%b expected 0", bus.out_valid);
      end
      offer(5'd1, 5'd2, 5'd3, 32'h0, 32'h308, 16'h0);
      flush = 1'b1;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++; $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready);
      end
      step();
      flush = 1'b0;
      offer(5'd1, 5'd2, 5'd3, 32'h0, 32'h30C, 16'h0);
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++; $display("FAIL flush_empty: got out_valid=%b expected 0", bus.out_valid);
      end
      step();
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h30C) begin
         miscompares++; $display("FAIL flush_recover: got v=%b pc=%h expected v=1 30c", bus.out_valid, bus.out_pc);
      end
      $display("flush: recovered pc=%h", bus.out_pc);
      step();
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_bypass();
      test_stall_update();
      test_back_to_back();
      test_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
